// File: rtl/uart_tx_ce.sv
// UART transmitter paced by a one-cycle bit enable (ce): start bit, LSB-first data, optional parity, stop bits.
// Start bit on the first ce after acceptance; tx_ready is low (words held off) from acceptance until frame end.
module uart_tx_ce #(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ce,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy
);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_ce: DATA_BITS must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx_ce: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_tx_ce: STOP_BITS must be 1 or 2");
  end

  localparam int             CW        = $clog2(DATA_BITS);
  localparam logic [CW-1:0]  LAST_BIT  = CW'(DATA_BITS - 1);
  localparam logic           LAST_STOP = (STOP_BITS == 2);
  localparam logic           HAS_PAR   = (PARITY != 0);
  localparam logic           ODD       = (PARITY == 2);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SYNC  = 3'd1,
    START = 3'd2,
    DATA  = 3'd3,
    PAR   = 3'd4,
    STOP  = 3'd5
  } state_t;

  state_t               state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [CW-1:0]        bit_cnt_q, bit_cnt_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      par_q      <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      par_q      <= par_d;
      tx_q       <= tx_d;
    end
  end

  // Only acceptance ignores ce; every other move waits for the bit tick.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (tx_valid) state_d = SYNC;
      SYNC:    if (ce) state_d = START;
      START:   if (ce) state_d = DATA;
      DATA:    if (ce && bit_cnt_q == LAST_BIT) state_d = HAS_PAR ? PAR : STOP;
      PAR:     if (ce) state_d = STOP;
      STOP:    if (ce && stop_cnt_q == LAST_STOP) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Parity is folded at acceptance so the shifter can discard bits as they go out.
  always_comb begin
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    par_d      = par_q;
    tx_d       = tx_q;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (tx_valid) begin
          shift_d = tx_data;
          par_d   = (^tx_data) ^ ODD;
        end
      end
      SYNC: if (ce) tx_d = 1'b0;
      START: begin
        if (ce) begin
          tx_d      = shift_q[0];
          bit_cnt_d = '0;
        end
      end
      DATA: begin
        if (ce) begin
          if (bit_cnt_q != LAST_BIT) begin
            bit_cnt_d = bit_cnt_q + CW'(1);
            shift_d   = shift_q >> 1;
            tx_d      = shift_q[1];
          end else if (HAS_PAR) begin
            tx_d = par_q;
          end else begin
            tx_d       = 1'b1;
            stop_cnt_d = 1'b0;
          end
        end
      end
      PAR: begin
        if (ce) begin
          tx_d       = 1'b1;
          stop_cnt_d = 1'b0;
        end
      end
      STOP: if (ce && stop_cnt_q != LAST_STOP) stop_cnt_d = stop_cnt_q + 1'b1;
      default: tx_d = 1'b1;
    endcase
  end

  assign tx       = tx_q;
  assign busy     = (state_q != IDLE);
  assign tx_ready = (state_q == IDLE) && !rst;

endmodule

// File: tb/tb_uart_tx_ce.sv
// Bench for uart_tx_ce: four configurations (8N1, 8E1, 8O1, 7N2) share clk/rst/ce,
// a frame-level model predicts tx/busy/tx_ready every cycle, literal frames pin the model.
module tb_uart_tx_ce;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ce  = 1'b0;
  logic [3:0] valid_v = '0;
  logic [8:0] data_v [4];
  logic [3:0] tx_o, busy_o, ready_o;

  int   errors = 0;
  int   checks = 0;
  int   ce_mode = 0;   // 0: held low, 1: held high, 2: one pulse every 4 clk
  int   div_cnt = 0;
  logic last_ce = 1'b0;

  always #5 clk = ~clk;

  uart_tx_ce #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_dut_8n1 (
    .clk(clk), .rst(rst), .ce(ce), .tx_data(data_v[0][7:0]), .tx_valid(valid_v[0]),
    .tx_ready(ready_o[0]), .tx(tx_o[0]), .busy(busy_o[0]));
  uart_tx_ce #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_dut_8e1 (
    .clk(clk), .rst(rst), .ce(ce), .tx_data(data_v[1][7:0]), .tx_valid(valid_v[1]),
    .tx_ready(ready_o[1]), .tx(tx_o[1]), .busy(busy_o[1]));
  uart_tx_ce #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_dut_8o1 (
    .clk(clk), .rst(rst), .ce(ce), .tx_data(data_v[2][7:0]), .tx_valid(valid_v[2]),
    .tx_ready(ready_o[2]), .tx(tx_o[2]), .busy(busy_o[2]));
  uart_tx_ce #(.DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u_dut_7n2 (
    .clk(clk), .rst(rst), .ce(ce), .tx_data(data_v[3][6:0]), .tx_valid(valid_v[3]),
    .tx_ready(ready_o[3]), .tx(tx_o[3]), .busy(busy_o[3]));

  function automatic int lane_d(input int l);
    return (l == 3) ? 7 : 8;
  endfunction
  function automatic int lane_p(input int l);
    return (l == 1) ? 1 : ((l == 2) ? 2 : 0);
  endfunction
  function automatic int lane_s(input int l);
    return (l == 3) ? 2 : 1;
  endfunction

  // Line value for each ce period: bit 0 is the start bit, stop bits and beyond are 1.
  function automatic logic [15:0] frame_of(input int l, input logic [8:0] d);
    logic [15:0] f;
    int ones;
    f    = '1;
    ones = 0;
    f[0] = 1'b0;
    for (int i = 0; i < lane_d(l); i++) begin
      f[1 + i] = d[i];
      if (d[i]) ones++;
    end
    if (lane_p(l) != 0) f[1 + lane_d(l)] = ((ones % 2) == 1) ^ (lane_p(l) == 2);
    return f;
  endfunction

  // Model: k = number of ce pulses since acceptance; busy until the ce that follows the last frame bit.
  logic [3:0]  m_busy = '0;
  int          m_k [4];
  int          m_n [4];
  logic [15:0] m_frame [4];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= '0;
      for (int l = 0; l < 4; l++) m_k[l] <= 0;
    end else begin
      for (int l = 0; l < 4; l++) begin
        if (m_busy[l]) begin
          if (ce) begin
            m_k[l] <= m_k[l] + 1;
            if (m_k[l] >= m_n[l]) m_busy[l] <= 1'b0;
          end
        end else if (valid_v[l]) begin
          m_busy[l]  <= 1'b1;
          m_k[l]     <= 0;
          m_frame[l] <= frame_of(l, data_v[l]);
          m_n[l]     <= 1 + lane_d(l) + ((lane_p(l) != 0) ? 1 : 0) + lane_s(l);
        end
      end
    end
  end

  always @(posedge clk) last_ce <= ce;

  task automatic check(input string name, input int l, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s lane%0d: got %b expected %b at %0t", name, l, act, exp, $time);
    end
  endtask

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int l = 0; l < 4; l++) begin
      logic exp_tx;
      exp_tx = (m_busy[l] && m_k[l] >= 1) ? m_frame[l][m_k[l] - 1] : 1'b1;
      check("tx", l, tx_o[l], exp_tx);
      check("busy", l, busy_o[l], m_busy[l]);
      check("ready", l, ready_o[l], !m_busy[l] && !rst);
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      case (ce_mode)
        0: ce = 1'b0;
        1: ce = 1'b1;
        default: begin
          div_cnt = (div_cnt == 3) ? 0 : div_cnt + 1;
          ce = (div_cnt == 3);
        end
      endcase
    end
  end

  task automatic send(input int l, input logic [8:0] d);
    valid_v[l] = 1'b1;
    data_v[l]  = d;
    @(negedge clk);
    valid_v[l] = 1'b0;
    data_v[l]  = 9'($urandom);
  endtask

  task automatic send_all(input logic [8:0] d);
    valid_v = 4'hF;
    for (int l = 0; l < 4; l++) data_v[l] = d;
    @(negedge clk);
    valid_v = 4'h0;
    for (int l = 0; l < 4; l++) data_v[l] = 9'($urandom);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((m_busy != 4'h0 || busy_o != 4'h0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL idle_timeout: still busy %b after %0d cycles", busy_o, budget);
    end
  endtask

  // With ce held high each sample after acceptance is one bit period; first sample is SYNC.
  task automatic frame_literal(input int l, input logic [8:0] d, input int n, input logic [11:0] exp);
    logic [11:0] rec;
    int low;
    rec = '0;
    low = 0;
    send(l, d);
    for (int i = 0; i < n; i++) begin
      rec = {rec[10:0], tx_o[l]};
      if (!ready_o[l]) low++;
      @(negedge clk);
    end
    check_val("frame_bits", 32'(rec), 32'(exp));
    check_val("busy_cycles", 32'(low), 32'(n));
    check_val("ready_back", 32'(ready_o[l]), 32'd1);
  endtask

  initial begin
    int   rdy_hi;
    int   falls;
    int   cnt;
    logic prev;
    for (int l = 0; l < 4; l++) data_v[l] = '0;

    repeat (2) @(negedge clk);
    check_val("reset_tx", 32'(tx_o), 32'hF);
    check_val("reset_busy", 32'(busy_o), 32'h0);
    check_val("reset_ready", 32'(ready_o), 32'h0);
    #2 rst = 1'b0;
    @(negedge clk);
    check_val("ready_after_reset", 32'(ready_o), 32'hF);

    ce_mode = 1;
    @(negedge clk);
    frame_literal(0, 9'h0A5, 11, 12'b0101_0100_1011);
    frame_literal(1, 9'h0A5, 12, 12'b1010_1001_0101);
    frame_literal(2, 9'h0A5, 12, 12'b1010_1001_0111);
    frame_literal(3, 9'h055, 11, 12'b0101_0101_0111);

    ce_mode = 2;
    @(negedge clk);
    begin
      logic [8:0] pats [6];
      pats = '{9'h0A5, 9'h000, 9'h0FF, 9'h03C, 9'h081, 9'h16E};
      for (int p = 0; p < 6; p++) begin
        send_all(pats[p]);
        wait_idle(200);
      end
    end

    // Back-to-back: tx_valid held high, second word waits for the first idle cycle.
    rdy_hi = 0;
    falls  = 0;
    prev   = 1'b1;
    valid_v[0] = 1'b1;
    data_v[0]  = 9'h000;
    @(negedge clk);
    data_v[0] = 9'h0FF;
    cnt = 0;
    while (!ready_o[0] && cnt < 200) begin
      if (prev && !tx_o[0]) falls++;
      prev = tx_o[0];
      @(negedge clk);
      cnt++;
    end
    rdy_hi++;
    @(negedge clk);
    valid_v[0] = 1'b0;
    data_v[0]  = 9'($urandom);
    check_val("second_accepted", 32'(ready_o[0]), 32'd0);
    cnt = 0;
    while ((busy_o[0] || m_busy[0]) && cnt < 200) begin
      if (prev && !tx_o[0]) falls++;
      prev = tx_o[0];
      if (ready_o[0]) rdy_hi++;
      @(negedge clk);
      cnt++;
    end
    check_val("ready_high_samples", 32'(rdy_hi), 32'd1);
    check_val("start_falls", 32'(falls), 32'd2);

    // Asynchronous reset in the middle of the data bits.
    send(0, 9'h000);
    cnt = 0;
    for (int i = 0; i < 100 && cnt < 4; i++) begin
      @(negedge clk);
      if (last_ce) cnt++;
    end
    check_val("mid_frame_busy", 32'(busy_o[0]), 32'd1);
    check_val("mid_frame_tx", 32'(tx_o[0]), 32'd0);
    #2 rst = 1'b1;
    #1;
    check_val("async_tx", 32'(tx_o[0]), 32'd1);
    check_val("async_busy", 32'(busy_o[0]), 32'd0);
    check_val("async_ready", 32'(ready_o[0]), 32'd0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check_val("ready_after_mid_reset", 32'(ready_o), 32'hF);
    ce_mode = 1;
    @(negedge clk);
    send_all(9'h1C3);
    wait_idle(100);

    // No ce: the frame parks in SYNC with the line idle.
    ce_mode = 0;
    @(negedge clk);
    send(0, 9'h03C);
    repeat (20) @(negedge clk);
    check_val("stall_busy", 32'(busy_o[0]), 32'd1);
    check_val("stall_tx", 32'(tx_o[0]), 32'd1);
    ce_mode = 1;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!last_ce && cnt < 10);
    check_val("first_ce_start", 32'(tx_o[0]), 32'd0);
    wait_idle(100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
